// File: rtl/multi_disp_slave_if.sv
// Parallel write side of the serial bus slave core feeding the display back end.
// The core drives the write strobe and mode; the display back end consumes them.
interface multi_disp_slave_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CH_BITS    = 1
);
    logic                  wr_en;
    logic [CH_BITS-1:0]    wr_ch;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  hex_mode;

    modport master (output wr_en, output wr_ch, output wr_data, output hex_mode);
    modport slave  (input  wr_en, input  wr_ch, input  wr_data, input  hex_mode);
endinterface

// File: rtl/multi_disp_slave.sv
// Multi-channel seven-segment back end. Each written buffer is converted by one shared
// sequential double-dabble engine and shown as active-low segment codes per digit.
module multi_disp_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int NUM_DIGITS = 3,
    parameter int CH_BITS    = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    multi_disp_slave_if.slave              bus,
    output logic                           busy_out,
    output logic [NUM_CH-1:0]              disp_valid,
    output logic [NUM_CH*NUM_DIGITS*7-1:0] seg_out
);

    // Enough BCD nibbles to hold the full conversion, so overflow can be detected.
    localparam int NBCD  = (DATA_WIDTH + 2) / 3;
    localparam int NNIB  = (NBCD > NUM_DIGITS) ? NBCD : NUM_DIGITS;
    localparam int BCD_W = 4 * NNIB;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

    state_t                state_p0;
    state_t                state_nxt;

    logic [DATA_WIDTH-1:0] chan_buf [NUM_CH];
    logic [NUM_CH-1:0]     dirty;
    logic [NUM_CH-1:0]     dirty_nxt;
    logic [CH_BITS-1:0]    rr;
    logic [CH_BITS-1:0]    cur_ch;
    logic [BCD_W-1:0]      bcd_p1;
    logic [DATA_WIDTH-1:0] bin_p1;
    logic [CNT_W-1:0]      cnt_p1;

    logic                  wr_hit;
    logic                  pick_found;
    logic [CH_BITS-1:0]    pick_ch;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  ovf;
    logic                  pick_en;
    logic                  load_en;
    logic                  shift_en;
    logic                  store_en;

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int n = 0; n < NNIB; n++) begin
            if (v[4*n +: 4] >= 4'd5) r[4*n +: 4] = v[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign wr_hit = bus.wr_en && (int'(bus.wr_ch) < NUM_CH);

    // Round-robin: first dirty channel at or after rr, wrapping.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr) + i) % NUM_CH;
            if (!pick_found && dirty[idx]) begin
                pick_found = 1'b1;
                pick_ch    = CH_BITS'(idx);
            end
        end
    end

    always_comb begin
        load_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(cur_ch) == c) load_val = chan_buf[c];
        end
    end

    always_comb begin
        ovf = 1'b0;
        for (int n = NUM_DIGITS; n < NNIB; n++) begin
            if (bcd_p1[4*n +: 4] != 4'd0) ovf = 1'b1;
        end
    end

    // A same-cycle write to the channel being loaded keeps it dirty.
    always_comb begin
        dirty_nxt = dirty;
        for (int c = 0; c < NUM_CH; c++) begin
            if (load_en && int'(cur_ch) == c) dirty_nxt[c] = 1'b0;
            if (wr_hit && int'(bus.wr_ch) == c) dirty_nxt[c] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_p0 <= IDLE;
        else       state_p0 <= state_nxt;
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:    if (pick_found) state_nxt = LOAD;
            LOAD:    state_nxt = bus.hex_mode ? STORE : SHIFT;
            SHIFT:   if (cnt_p1 == CNT_W'(DATA_WIDTH - 1)) state_nxt = STORE;
            STORE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pick_en  = (state_p0 == IDLE) && pick_found;
        load_en  = (state_p0 == LOAD);
        shift_en = (state_p0 == SHIFT);
        store_en = (state_p0 == STORE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) chan_buf[c] <= '0;
            dirty      <= '0;
            rr         <= '0;
            cur_ch     <= '0;
            bcd_p1     <= '0;
            bin_p1     <= '0;
            cnt_p1     <= '0;
            busy_out   <= 1'b0;
            disp_valid <= '0;
            seg_out    <= '1;
        end else begin
            dirty    <= dirty_nxt;
            busy_out <= (|dirty) || (state_p0 != IDLE);

            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_hit && int'(bus.wr_ch) == c) chan_buf[c] <= bus.wr_data;
            end

            if (pick_en) cur_ch <= pick_ch;

            // ---- load: hex places nibbles straight into the digit register ----
            if (load_en) begin
                cnt_p1 <= '0;
                if (bus.hex_mode) begin
                    bcd_p1 <= BCD_W'(load_val);
                    bin_p1 <= '0;
                end else begin
                    bcd_p1 <= '0;
                    bin_p1 <= load_val;
                end
            end

            // ---- shift: one double-dabble step per cycle ----
            if (shift_en) begin
                {bcd_p1, bin_p1} <= {dabble_adj(bcd_p1), bin_p1} << 1;
                cnt_p1           <= cnt_p1 + 1'b1;
            end

            // ---- store: publish digits of the converted channel ----
            if (store_en) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(cur_ch) == c) begin
                        disp_valid[c] <= 1'b1;
                        for (int d = 0; d < NUM_DIGITS; d++) begin
                            seg_out[(c*NUM_DIGITS + d)*7 +: 7] <=
                                ovf ? SEG_DASH : seg_code(bcd_p1[4*d +: 4]);
                        end
                    end
                end
                rr <= (int'(cur_ch) == NUM_CH - 1) ? '0 : cur_ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_disp_slave.sv
// Directed bench for multi_disp_slave: a default instance (3 digits) and a 2-digit
// instance with a wider channel field, checked against a division-based reference.
module tb_multi_disp_slave;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    multi_disp_slave_if #(.DATA_WIDTH(8), .CH_BITS(1)) bus ();
    multi_disp_slave_if #(.DATA_WIDTH(8), .CH_BITS(2)) bus2 ();

    logic        busy, busy2;
    logic [1:0]  dv, dv2;
    logic [41:0] seg;
    logic [27:0] seg2;

    multi_disp_slave #(.DATA_WIDTH(8), .NUM_CH(2), .NUM_DIGITS(3), .CH_BITS(1)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .busy_out(busy), .disp_valid(dv), .seg_out(seg)
    );

    multi_disp_slave #(.DATA_WIDTH(8), .NUM_CH(2), .NUM_DIGITS(2), .CH_BITS(2)) dut2 (
        .clk(clk), .rstn(rstn), .bus(bus2),
        .busy_out(busy2), .disp_valid(dv2), .seg_out(seg2)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          dut_id;
        int          ch;
        logic [20:0] seg;
        int          at;
    } exp_t;
    exp_t sb[$];

    function automatic logic [6:0] ref_code(int n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    function automatic logic [20:0] model(int v, bit hex, int nd);
        logic [20:0] r;
        int base, x;
        bit over;
        base = hex ? 16 : 10;
        over = (v >= base ** nd);
        x    = v;
        r    = '0;
        for (int d = 0; d < nd; d++) begin
            r[d*7 +: 7] = over ? 7'b0111111 : ref_code(x % base);
            x = x / base;
        end
        return r;
    endfunction

    function automatic logic [20:0] slice(int id, int ch);
        if (id == 0) return seg[ch*21 +: 21];
        return {7'b0, seg2[ch*14 +: 14]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [41:0] obs, logic [41:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(string tag, logic [41:0] obs, logic [41:0] exp);
        total++;
        assert (obs !== exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected a value other than %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(int id, int ch, int data, output int cap);
        if (id == 0) begin
            bus.wr_ch   = 1'(ch);
            bus.wr_data = 8'(data);
            bus.wr_en   = 1'b1;
        end else begin
            bus2.wr_ch   = 2'(ch);
            bus2.wr_data = 8'(data);
            bus2.wr_en   = 1'b1;
        end
        tick();
        bus.wr_en  = 1'b0;
        bus2.wr_en = 1'b0;
        cap = edge_cnt;
    endtask

    task automatic push(int id, int ch, int v, bit hex, int at);
        exp_t e;
        e.dut_id = id;
        e.ch     = ch;
        e.seg    = model(v, hex, (id == 0) ? 3 : 2);
        e.at     = at;
        sb.push_back(e);
    endtask

    // Pops the oldest expectation, checks the value is absent one edge early and present on time.
    task automatic drain(string tag);
        exp_t e;
        int guard;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: observed empty scoreboard, expected a pending result", tag);
            return;
        end
        e = sb.pop_front();
        guard = 0;
        while (edge_cnt < e.at - 1 && guard < 200) begin
            tick();
            guard++;
        end
        chk_ne({tag, "_early"}, 42'(slice(e.dut_id, e.ch)), 42'(e.seg));
        tick();
        chk(tag, 42'(slice(e.dut_id, e.ch)), 42'(e.seg));
    endtask

    initial begin
        int c0, c1, c2, cap;
        logic [27:0] s2;
        logic [1:0]  d2;

        bus.wr_en     = 1'b0;
        bus.wr_ch     = '0;
        bus.wr_data   = '0;
        bus.hex_mode  = 1'b0;
        bus2.wr_en    = 1'b0;
        bus2.wr_ch    = '0;
        bus2.wr_data  = '0;
        bus2.hex_mode = 1'b0;

        repeat (2) tick();
        chk("rst_seg", 42'(seg), {42{1'b1}});
        chk("rst_dv", 42'(dv), 42'(0));
        chk("rst_busy", 42'(busy), 42'(0));
        rstn = 1'b1;
        tick();

        // decimal 255 on ch0
        wr(0, 0, 255, c0);
        chk("busy_at_capture", 42'(busy), 42'(0));
        tick();
        chk("busy_rise", 42'(busy), 42'(1));
        push(0, 0, 255, 1'b0, c0 + 11);
        drain("dec255");
        chk("dv_after_255", 42'(dv), 42'(2'b01));
        tick();
        chk("busy_fall_255", 42'(busy), 42'(0));

        // hex AB on ch1
        bus.hex_mode = 1'b1;
        wr(0, 1, 'hAB, c0);
        push(0, 1, 'hAB, 1'b1, c0 + 3);
        drain("hexAB");
        chk("dv_after_AB", 42'(dv), 42'(2'b11));
        chk("ch0_kept", 42'(slice(0, 0)), 42'(model(255, 1'b0, 3)));
        repeat (2) tick();
        bus.hex_mode = 1'b0;
        repeat (4) tick();
        chk("mode_change_busy", 42'(busy), 42'(0));
        chk("mode_change_ch1", 42'(slice(0, 1)), 42'(model('hAB, 1'b1, 3)));

        // back-to-back writes plus a rewrite during ch0's shift
        wr(0, 0, 12, c0);
        push(0, 0, 12, 1'b0, c0 + 11);
        wr(0, 1, 34, c1);
        push(0, 1, 34, 1'b0, c0 + 22);
        repeat (3) tick();
        wr(0, 0, 56, c2);
        push(0, 0, 56, 1'b0, c0 + 33);
        drain("rr_ch0_12");
        drain("rr_ch1_34");
        drain("rr_ch0_56");
        chk("busy_last_store", 42'(busy), 42'(1));
        tick();
        chk("busy_fall_rr", 42'(busy), 42'(0));
        chk("rr_ch1_final", 42'(slice(0, 1)), 42'(model(34, 1'b0, 3)));

        // two-digit instance: overflow then in-range
        wr(1, 0, 200, cap);
        push(1, 0, 200, 1'b0, cap + 11);
        drain("ovf200");
        wr(1, 0, 99, cap);
        push(1, 0, 99, 1'b0, cap + 11);
        drain("dec99");
        chk("dv2_after_99", 42'(dv2), 42'(2'b01));

        // out-of-range channel is ignored
        repeat (2) tick();
        s2 = seg2;
        d2 = dv2;
        wr(1, 2, 'h55, cap);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("badch_busy", 42'(busy2), 42'(0));
        end
        chk("badch_seg", 42'(seg2), 42'(s2));
        chk("badch_dv", 42'(dv2), 42'(d2));

        // reset asserted in the middle of a conversion
        wr(0, 0, 77, cap);
        repeat (4) tick();
        #2 rstn = 1'b0;
        #1;
        chk("midrst_seg", 42'(seg), {42{1'b1}});
        chk("midrst_dv", 42'(dv), 42'(0));
        chk("midrst_busy", 42'(busy), 42'(0));
        chk("midrst_seg2", 42'(seg2), 42'({28{1'b1}}));
        chk("midrst_dv2", 42'(dv2), 42'(0));
        chk("midrst_busy2", 42'(busy2), 42'(0));
        rstn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
